// File: rtl/abs_diff_err_sweep.sv
`default_nettype none
// ============================================================================
//  Module   : abs_diff_err_sweep
//  Purpose  : Exhaustively sweeps the 16 input vectors of a 2-bit absolute-
//             difference approximate circuit, compares each response against
//             the exact |A-B| and accumulates error statistics
//             (sum, maximum, count above threshold ET).
//  Option   : ABS_DIFF_SWEEP_FIRSTFAIL_EN adds fail_valid/fail_vec, which
//             capture the first vector of a sweep whose error exceeds ET.
//  Revision : 1.0  initial release
// ============================================================================
module abs_diff_err_sweep #(
  parameter int ET = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] drv_vec,
  input  logic [1:0] approx_out,
  output logic       busy,
  output logic       done,
  output logic [5:0] err_sum,
  output logic [1:0] max_err,
  output logic [4:0] fail_cnt,
  output logic       pass
`ifdef ABS_DIFF_SWEEP_FIRSTFAIL_EN
  ,
  output logic       fail_valid,
  output logic [3:0] fail_vec
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] ET_LIM   = ET[1:0];
  localparam logic [3:0] LAST_VEC = 4'd15;

  logic [1:0] state;
  logic [1:0] state_nxt;

  // Compare stage: one vector and its response, scored on the following edge
  logic       cmp_valid;
  logic [3:0] cmp_vec;
  logic [1:0] cmp_approx;

  logic       start_ok;
  logic [1:0] op_a;
  logic [1:0] op_b;
  logic [1:0] exact;
  logic [1:0] err;
  logic       is_fail;

  // A start is only honoured while no sweep is in progress
  assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));

  // Score the compare-stage vector: exact = |A-B|, err = |exact - approx|
  always_comb begin
    op_a    = cmp_vec[1:0];
    op_b    = cmp_vec[3:2];
    exact   = (op_a >= op_b) ? (op_a - op_b) : (op_b - op_a);
    err     = (exact >= cmp_approx) ? (exact - cmp_approx) : (cmp_approx - exact);
    is_fail = (err > ET_LIM);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: RUN covers 16 edges, DRAIN scores the last vector
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_RUN;
      S_RUN:   if (drv_vec == LAST_VEC) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  if (start_ok) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs decoded from the current state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_RUN,
      S_DRAIN: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign pass = done && (fail_cnt == 5'd0);

  // Vector generator, compare stage and accumulators
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drv_vec    <= 4'd0;
      cmp_valid  <= 1'b0;
      cmp_vec    <= 4'd0;
      cmp_approx <= 2'd0;
      err_sum    <= 6'd0;
      max_err    <= 2'd0;
      fail_cnt   <= 5'd0;
    end else if (start_ok) begin
      drv_vec    <= 4'd0;
      cmp_valid  <= 1'b0;
      err_sum    <= 6'd0;
      max_err    <= 2'd0;
      fail_cnt   <= 5'd0;
    end else begin
      if (state == S_RUN) begin
        cmp_valid  <= 1'b1;
        cmp_vec    <= drv_vec;
        cmp_approx <= approx_out;
        drv_vec    <= drv_vec + 4'd1;
      end else begin
        cmp_valid  <= 1'b0;
      end
      if (cmp_valid) begin
        err_sum <= err_sum + {4'b0000, err};
        if (err > max_err) max_err <= err;
        if (is_fail) fail_cnt <= fail_cnt + 5'd1;
      end
    end
  end

`ifdef ABS_DIFF_SWEEP_FIRSTFAIL_EN
  // First failing vector of the sweep; later failures leave it untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_valid <= 1'b0;
      fail_vec   <= 4'd0;
    end else if (start_ok) begin
      fail_valid <= 1'b0;
      fail_vec   <= 4'd0;
    end else if (cmp_valid && is_fail && !fail_valid) begin
      fail_valid <= 1'b1;
      fail_vec   <= cmp_vec;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_abs_diff_err_sweep.sv
`default_nettype none
// ============================================================================
//  Module   : tb_abs_diff_err_sweep
//  Purpose  : Self-checking bench for abs_diff_err_sweep. The approximate
//             circuit is a lookup table indexed by drv_vec; expected results
//             come from a reference model that scores all 16 vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_abs_diff_err_sweep;

  localparam int ET_P = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] drv_vec;
  logic [1:0] approx_out;
  logic       busy;
  logic       done;
  logic [5:0] err_sum;
  logic [1:0] max_err;
  logic [4:0] fail_cnt;
  logic       pass;
`ifdef ABS_DIFF_SWEEP_FIRSTFAIL_EN
  logic       fail_valid;
  logic [3:0] fail_vec;
`endif

  logic [1:0] lut [16];

  int tests = 0;
  int fails = 0;

  int exp_sum, exp_max, exp_fail, exp_ff_valid, exp_ff_vec;

  always #5 clk = ~clk;

  assign approx_out = lut[drv_vec];

  abs_diff_err_sweep #(.ET(ET_P)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .drv_vec    (drv_vec),
    .approx_out (approx_out),
    .busy       (busy),
    .done       (done),
    .err_sum    (err_sum),
    .max_err    (max_err),
    .fail_cnt   (fail_cnt),
    .pass       (pass)
`ifdef ABS_DIFF_SWEEP_FIRSTFAIL_EN
    ,
    .fail_valid (fail_valid),
    .fail_vec   (fail_vec)
`endif
  );

  // Reference model: score every vector of the current table
  task automatic model();
    exp_sum = 0; exp_max = 0; exp_fail = 0; exp_ff_valid = 0; exp_ff_vec = 0;
    for (int v = 0; v < 16; v++) begin
      int a, b, ex, ap, e;
      a  = v % 4;
      b  = v / 4;
      ex = (a > b) ? a - b : b - a;
      ap = int'(lut[v]);
      e  = (ex > ap) ? ex - ap : ap - ex;
      exp_sum += e;
      if (e > exp_max) exp_max = e;
      if (e > ET_P) begin
        exp_fail++;
        if (exp_ff_valid == 0) begin
          exp_ff_valid = 1;
          exp_ff_vec   = v;
        end
      end
    end
  endtask

  task automatic fill_exact();
    for (int v = 0; v < 16; v++) begin
      int a, b;
      a = v % 4;
      b = v / 4;
      lut[v] = 2'((a > b) ? a - b : b - a);
    end
  endtask

  task automatic fill_const(input logic [1:0] c);
    for (int v = 0; v < 16; v++) lut[v] = c;
  endtask

  task automatic fill_random();
    for (int v = 0; v < 16; v++) lut[v] = 2'($urandom_range(0, 3));
  endtask

  // Pulse start for one edge, then count edges until done (bounded)
  task automatic run_sweep(output int edges);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    edges = 0;
    while (!done && edges < 40) begin
      @(posedge clk);
      #1 edges++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    fill_const(2'd0);
    #3;
    tests++;
    if ({drv_vec, busy, done, err_sum, max_err, fail_cnt, pass} !== 20'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h required 0",
               {drv_vec, busy, done, err_sum, max_err, fail_cnt, pass});
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || drv_vec !== 4'd0) begin
      fails++;
      $display("FAIL idle_hold: got busy=%b done=%b vec=%0d required 0 0 0", busy, done, drv_vec);
    end
  endtask

  task automatic test_exact();
    int edges;
    fill_exact();
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    tests++;
    if (busy !== 1'b1 || drv_vec !== 4'd0 || err_sum !== 6'd0) begin
      fails++;
      $display("FAIL exact_e0: got busy=%b vec=%0d sum=%0d required 1 0 0", busy, drv_vec, err_sum);
    end
    edges = 0;
    while (!done && edges < 40) begin
      @(posedge clk);
      #1 edges++;
      if (edges <= 15) begin
        tests++;
        if (drv_vec !== 4'(edges)) begin
          fails++;
          $display("FAIL exact_vec: got %0d required %0d", drv_vec, edges);
        end
      end
    end
    tests++;
    if (edges != 17) begin
      fails++;
      $display("FAIL exact_latency: got %0d edges required 17", edges);
    end
    tests++;
    if (err_sum !== 6'd0 || max_err !== 2'd0 || fail_cnt !== 5'd0 || pass !== 1'b1) begin
      fails++;
      $display("FAIL exact_result: got sum=%0d max=%0d fcnt=%0d pass=%b required 0 0 0 1",
               err_sum, max_err, fail_cnt, pass);
    end
    tests++;
    if (drv_vec !== 4'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL exact_done_vec: got vec=%0d busy=%b required 0 0", drv_vec, busy);
    end
  endtask

  task automatic test_const(input logic [1:0] c, input int rs, input int rf, input int rv);
    int edges;
    fill_const(c);
    run_sweep(edges);
    tests++;
    if (edges != 17 || err_sum !== 6'(rs) || max_err !== 2'd3 || fail_cnt !== 5'(rf) || pass !== 1'b0) begin
      fails++;
      $display("FAIL const%0d_result: got edges=%0d sum=%0d max=%0d fcnt=%0d pass=%b required 17 %0d 3 %0d 0",
               c, edges, err_sum, max_err, fail_cnt, pass, rs, rf);
    end
`ifdef ABS_DIFF_SWEEP_FIRSTFAIL_EN
    tests++;
    if (fail_valid !== 1'b1 || fail_vec !== 4'(rv)) begin
      fails++;
      $display("FAIL const%0d_firstfail: got %b/%0d required 1/%0d", c, fail_valid, fail_vec, rv);
    end
`else
    if (rv < 0) $display("unused %0d", rv);
`endif
  endtask

  task automatic test_random();
    int edges;
    for (int r = 0; r < 6; r++) begin
      fill_random();
      model();
      run_sweep(edges);
      tests++;
      if (edges != 17 || err_sum !== 6'(exp_sum) || max_err !== 2'(exp_max) ||
          fail_cnt !== 5'(exp_fail) || pass !== (exp_fail == 0)) begin
        fails++;
        $display("FAIL random%0d_result: got edges=%0d sum=%0d max=%0d fcnt=%0d pass=%b required 17 %0d %0d %0d %0d",
                 r, edges, err_sum, max_err, fail_cnt, pass, exp_sum, exp_max, exp_fail, exp_fail == 0);
      end
`ifdef ABS_DIFF_SWEEP_FIRSTFAIL_EN
      tests++;
      if (fail_valid !== 1'(exp_ff_valid) || fail_vec !== 4'(exp_ff_vec)) begin
        fails++;
        $display("FAIL random%0d_firstfail: got %b/%0d required %0d/%0d",
                 r, fail_valid, fail_vec, exp_ff_valid, exp_ff_vec);
      end
`endif
      // Results must hold in DONE even if the circuit response changes
      fill_random();
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (done !== 1'b1 || err_sum !== 6'(exp_sum) || fail_cnt !== 5'(exp_fail) || drv_vec !== 4'd0) begin
        fails++;
        $display("FAIL random%0d_hold: got done=%b sum=%0d fcnt=%0d vec=%0d required 1 %0d %0d 0",
                 r, done, err_sum, fail_cnt, drv_vec, exp_sum, exp_fail);
      end
    end
  endtask

  task automatic test_start_ignored();
    int edges;
    fill_random();
    model();
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    edges = 5;
    tests++;
    if (drv_vec !== 4'd5 || busy !== 1'b1) begin
      fails++;
      $display("FAIL ignored_vec: got vec=%0d busy=%b required 5 1", drv_vec, busy);
    end
    while (!done && edges < 40) begin
      @(posedge clk);
      #1 edges++;
    end
    tests++;
    if (edges != 17 || err_sum !== 6'(exp_sum) || max_err !== 2'(exp_max) || fail_cnt !== 5'(exp_fail)) begin
      fails++;
      $display("FAIL ignored_result: got edges=%0d sum=%0d max=%0d fcnt=%0d required 17 %0d %0d %0d",
               edges, err_sum, max_err, fail_cnt, exp_sum, exp_max, exp_fail);
    end
  endtask

  task automatic test_reset_mid();
    int edges;
    fill_const(2'd3);
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({drv_vec, busy, done, err_sum, max_err, fail_cnt, pass} !== 20'd0) begin
      fails++;
      $display("FAIL midreset_async: got %h required 0",
               {drv_vec, busy, done, err_sum, max_err, fail_cnt, pass});
    end
    @(posedge clk); #1;
    tests++;
    if ({drv_vec, busy, done, err_sum, max_err, fail_cnt, pass} !== 20'd0) begin
      fails++;
      $display("FAIL midreset_hold: got %h required 0",
               {drv_vec, busy, done, err_sum, max_err, fail_cnt, pass});
    end
    @(negedge clk) rst = 1'b0;
    fill_random();
    model();
    run_sweep(edges);
    tests++;
    if (edges != 17 || err_sum !== 6'(exp_sum) || max_err !== 2'(exp_max) || fail_cnt !== 5'(exp_fail)) begin
      fails++;
      $display("FAIL midreset_result: got edges=%0d sum=%0d max=%0d fcnt=%0d required 17 %0d %0d %0d",
               edges, err_sum, max_err, fail_cnt, exp_sum, exp_max, exp_fail);
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    fill_const(2'd0);
    run_sweep(edges);
    fill_exact();
    run_sweep(edges);
    tests++;
    if (edges != 17 || err_sum !== 6'd0 || max_err !== 2'd0 || fail_cnt !== 5'd0 || pass !== 1'b1) begin
      fails++;
      $display("FAIL b2b_result: got edges=%0d sum=%0d max=%0d fcnt=%0d pass=%b required 17 0 0 0 1",
               edges, err_sum, max_err, fail_cnt, pass);
    end
`ifdef ABS_DIFF_SWEEP_FIRSTFAIL_EN
    tests++;
    if (fail_valid !== 1'b0 || fail_vec !== 4'd0) begin
      fails++;
      $display("FAIL b2b_firstfail: got %b/%0d required 0/0", fail_valid, fail_vec);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_exact();
    test_const(2'd0, 20, 6, 2);
    test_const(2'd3, 28, 10, 0);
    test_random();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/abs_diff_err_sweep.md
ABS_DIFF_ERR_SWEEP -- requirements
Module: abs_diff_err_sweep

Interface
REQ-001 SHALL have parameter ET, default 3, meaning the error threshold (0..3) a single vector's absolute error must not exceed.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port start  input  1  sweep request, sampled in IDLE and DONE only.
REQ-005 SHALL have port drv_vec  output  4  stimulus to the approximate circuit; bit i drives in_i.
REQ-006 SHALL have port approx_out  input  2  approximate circuit response {out1,out0}, combinational from drv_vec.
REQ-007 SHALL have port busy  output  1  high in RUN and DRAIN.
REQ-008 SHALL have port done  output  1  high in DONE.
REQ-009 SHALL have port err_sum  output  6  sum of per-vector absolute errors (max 48).
REQ-010 SHALL have port max_err  output  2  largest per-vector absolute error.
REQ-011 SHALL have port fail_cnt  output  5  count of vectors with error > ET (0..16).
REQ-012 SHALL have port pass  output  1  high when done and fail_cnt == 0.

Function
REQ-013 SHALL compute exact = |A - B|, A = drv_vec[1:0], B = drv_vec[3:2], 2-bit unsigned.
REQ-014 SHALL compute per-vector error = |exact - approx_out|, 2-bit unsigned.
REQ-015 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-016 IDLE/DONE with start=1 at edge E0: SHALL clear err_sum, max_err, fail_cnt, set drv_vec=0, enter RUN.
REQ-017 RUN: at edges E1..E16 SHALL register (drv_vec, approx_out) into a compare stage and increment drv_vec; drv_vec wraps 15->0 at E16, when the FSM enters DRAIN.
REQ-018 Accumulators SHALL update at E2..E17 from the compare stage only; DRAIN SHALL last one cycle and enter DONE at E17.
REQ-019 done SHALL rise after E17 and stay high until the next accepted start or reset.
REQ-020 start while busy SHALL be ignored without effect on state, vector, or accumulators.
REQ-021 err_sum, max_err, fail_cnt SHALL never wrap or saturate within a sweep (widths sized for 16 vectors).
REQ-022 drv_vec SHALL hold 0 in IDLE and hold its wrapped value 0 in DONE.
REQ-023 Result outputs SHALL remain stable in DONE until the next accepted start.

Reset
REQ-024 rst=1 SHALL asynchronously force IDLE, drv_vec=0, busy=0, done=0, err_sum=0, max_err=0, fail_cnt=0, pass=0, compare stage cleared.
REQ-025 rst mid-sweep SHALL abandon the sweep; next start SHALL begin at vector 0.

Configuration
REQ-026 Macro ABS_DIFF_SWEEP_FIRSTFAIL_EN defined: SHALL add outputs fail_valid (1) and fail_vec (4), capturing the first vector whose error > ET in a sweep; both cleared to 0 by reset and accepted start.
REQ-027 Macro undefined: fail_valid and fail_vec SHALL not exist and no capture logic SHALL be synthesized; all other behaviour identical.

Verification
REQ-028 approx_out tied to exact, ET=3, start pulse -> done after 17 edges, err_sum=0, max_err=0, fail_cnt=0, pass=1.
REQ-029 approx_out=0, ET=1 -> err_sum=20, max_err=3, fail_cnt=6, pass=0; with FIRSTFAIL_EN fail_valid=1, fail_vec=2.
REQ-030 approx_out=3, ET=1 -> err_sum=28, max_err=3, fail_cnt=10, pass=0; with FIRSTFAIL_EN fail_vec=0.
REQ-031 start re-pulsed at E5 of a sweep -> ignored; done still after E17, results match an uninterrupted sweep.
REQ-032 rst asserted at E8 then start -> all outputs 0 during reset; new sweep from vector 0 yields full correct results.
REQ-033 start in DONE with different approx_out -> accumulators cleared, new results reflect only the new sweep.
